// File: rtl/turn_scheduler.sv
// turn_scheduler: two-player turn controller for the 1A2B game.
// Grants the shared guess-entry path to one player at a time, handshakes each
// submitted guess with the A/B scorer, tracks remaining chances per player and
// declares a winner or a draw.
// Build option: define TURN_TIMER_EN to add the per-turn countdown and timeout
// forfeit. Without it, turns end only on entry_done and turn_secs_left and
// timeout_pulse are tied to 0.
module turn_scheduler #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TURN_SECS     = 30,
    parameter int MAX_CHANCES   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       first_player,
    input  logic       entry_done,
    input  logic       score_ack,
    input  logic       score_win,
    output logic       entry_en,
    output logic       active_player,
    output logic       score_req,
    output logic [5:0] turn_secs_left,
    output logic [2:0] chances_p0,
    output logic [2:0] chances_p1,
    output logic       timeout_pulse,
    output logic       winner_valid,
    output logic       winner,
    output logic       draw
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_SCORE,
        ST_SWITCH,
        ST_DONE
    } state_t;

    localparam logic [2:0] CHANCES_INIT = 3'(MAX_CHANCES);

    state_t     state_reg, state_next;
    logic       entry_en_reg, entry_en_next;
    logic       score_req_reg, score_req_next;
    logic       active_reg, active_next;
    logic       winner_reg, winner_next;
    logic       winner_valid_reg, winner_valid_next;
    logic       draw_reg, draw_next;
    logic [5:0] chances_all;

    // Qualified events: each input only matters in the state that consumes it
    logic start_go;
    logic ack_win;
    logic ack_miss;
    logic timeout_go;
    logic lose_chance;
    logic both_empty;
    logic other_has_chances;
    logic sw_draw;
    logic sw_cont;

    assign start_go          = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign ack_win           = (state_reg == ST_SCORE) && score_ack && score_win;
    assign ack_miss          = (state_reg == ST_SCORE) && score_ack && !score_win;
    assign lose_chance       = timeout_go || ack_miss;
    assign both_empty        = (chances_all == 6'd0);
    assign other_has_chances = active_reg ? (chances_all[2:0] != 3'd0) : (chances_all[5:3] != 3'd0);
    assign sw_draw           = (state_reg == ST_SWITCH) && both_empty;
    assign sw_cont           = (state_reg == ST_SWITCH) && !both_empty;

`ifdef TURN_TIMER_EN
    localparam int         PRE_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [5:0] SECS_INIT = 6'(TURN_SECS);

    logic [PRE_W-1:0] prescaler_reg, prescaler_next;
    logic [5:0]       secs_reg, secs_next;
    logic             timeout_reg;
    logic             tick_wrap;

    assign tick_wrap  = (state_reg == ST_ENTRY) && (prescaler_reg == PRE_W'(TICKS_PER_SEC - 1));
    // A confirmed guess on the final wrap wins over the forfeit
    assign timeout_go = tick_wrap && (secs_reg == 6'd1) && !entry_done;

    // Countdown: runs only while entry is open, reloads at the start of every turn
    always_comb begin
        prescaler_next = prescaler_reg;
        secs_next      = secs_reg;
        if (start_go || sw_cont) begin
            prescaler_next = '0;
            secs_next      = SECS_INIT;
        end else if (state_reg == ST_ENTRY && !entry_done) begin
            if (tick_wrap) begin
                prescaler_next = '0;
                secs_next      = secs_reg - 6'd1;
            end else begin
                prescaler_next = prescaler_reg + 1'b1;
            end
        end
    end

    // Countdown registers and the registered forfeit pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_reg <= '0;
            secs_reg      <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            prescaler_reg <= prescaler_next;
            secs_reg      <= secs_next;
            timeout_reg   <= timeout_go;
        end
    end

    assign turn_secs_left = secs_reg;
    assign timeout_pulse  = timeout_reg;
`else
    logic unused_timer_cfg;

    assign unused_timer_cfg = (TICKS_PER_SEC > 0) ^ (TURN_SECS > 0);
    assign timeout_go       = 1'b0;
    assign turn_secs_left   = '0;
    assign timeout_pulse    = 1'b0;
`endif

    // Per-player chance counters: reload on match start, saturating decrement on a lost turn
    for (genvar gi = 0; gi < 2; gi++) begin : g_chances
        logic [2:0] cnt_reg, cnt_next;

        // Next chance count for this player
        always_comb begin
            cnt_next = cnt_reg;
            if (start_go) begin
                cnt_next = CHANCES_INIT;
            end else if (lose_chance && (active_reg == 1'(gi)) && (cnt_reg != 3'd0)) begin
                cnt_next = cnt_reg - 3'd1;
            end
        end

        // Chance count register
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign chances_all[gi*3 +: 3] = cnt_reg;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            entry_en_reg     <= 1'b0;
            score_req_reg    <= 1'b0;
            active_reg       <= 1'b0;
            winner_reg       <= 1'b0;
            winner_valid_reg <= 1'b0;
            draw_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            entry_en_reg     <= entry_en_next;
            score_req_reg    <= score_req_next;
            active_reg       <= active_next;
            winner_reg       <= winner_next;
            winner_valid_reg <= winner_valid_next;
            draw_reg         <= draw_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (entry_done)      state_next = ST_SCORE;
                else if (timeout_go) state_next = ST_SWITCH;
            end
            ST_SCORE: begin
                if (score_ack) state_next = score_win ? ST_DONE : ST_SWITCH;
            end
            ST_SWITCH: begin
                state_next = both_empty ? ST_DONE : ST_ENTRY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        entry_en_next     = (state_next == ST_ENTRY);
        score_req_next    = (state_next == ST_SCORE);
        active_next       = active_reg;
        winner_next       = winner_reg;
        winner_valid_next = winner_valid_reg;
        draw_next         = draw_reg;
        if (start_go) begin
            active_next       = first_player;
            winner_next       = 1'b0;
            winner_valid_next = 1'b0;
            draw_next         = 1'b0;
        end
        if (ack_win) begin
            winner_next       = active_reg;
            winner_valid_next = 1'b1;
        end
        if (sw_draw) begin
            draw_next = 1'b1;
        end else if (sw_cont && other_has_chances) begin
            active_next = ~active_reg;
        end
    end

    assign entry_en      = entry_en_reg;
    assign score_req     = score_req_reg;
    assign active_player = active_reg;
    assign winner        = winner_reg;
    assign winner_valid  = winner_valid_reg;
    assign draw          = draw_reg;
    assign chances_p0    = chances_all[2:0];
    assign chances_p1    = chances_all[5:3];

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed scenarios plus a randomized run, all checked
// every cycle against a turn-level reference model (elapsed-cycle timer,
// per-player chance array). Follows TURN_TIMER_EN like the design.
`timescale 1ns/1ps
module tb_turn_scheduler;

    localparam int TICKS = 4;
    localparam int SECS  = 3;
    localparam int MAXC  = 2;

    localparam int P_IDLE   = 0;
    localparam int P_ENTRY  = 1;
    localparam int P_SCORE  = 2;
    localparam int P_SWITCH = 3;
    localparam int P_DONE   = 4;

    logic       clk = 1'b0;
    logic       reset, start, first_player, entry_done, score_ack, score_win;
    logic       entry_en, active_player, score_req, timeout_pulse;
    logic       winner_valid, winner, draw;
    logic [5:0] turn_secs_left;
    logic [2:0] chances_p0, chances_p1;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int m_phase, m_active, m_elapsed, m_win_valid, m_winner, m_draw, m_timeout;
    int m_ch [2];

    turn_scheduler #(
        .TICKS_PER_SEC(TICKS),
        .TURN_SECS    (SECS),
        .MAX_CHANCES  (MAXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .first_player  (first_player),
        .entry_done    (entry_done),
        .score_ack     (score_ack),
        .score_win     (score_win),
        .entry_en      (entry_en),
        .active_player (active_player),
        .score_req     (score_req),
        .turn_secs_left(turn_secs_left),
        .chances_p0    (chances_p0),
        .chances_p1    (chances_p1),
        .timeout_pulse (timeout_pulse),
        .winner_valid  (winner_valid),
        .winner        (winner),
        .draw          (draw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_active    = 0;
        m_elapsed   = 0;
        m_win_valid = 0;
        m_winner    = 0;
        m_draw      = 0;
        m_timeout   = 0;
        m_ch[0]     = 0;
        m_ch[1]     = 0;
    endtask

    task automatic model_lose();
        if (m_ch[m_active] > 0) m_ch[m_active]--;
    endtask

    // One clock edge of the turn-level model, using the inputs just applied
    task automatic model_step();
        m_timeout = 0;
        if (reset) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (start) begin
                    m_ch[0]     = MAXC;
                    m_ch[1]     = MAXC;
                    m_active    = int'(first_player);
                    m_win_valid = 0;
                    m_winner    = 0;
                    m_draw      = 0;
                    m_elapsed   = 0;
                    m_phase     = P_ENTRY;
                    $display("txn start first=%0d t=%0t", m_active, $time);
                end
            end
            P_ENTRY: begin
                if (entry_done) begin
                    m_phase = P_SCORE;
`ifdef TURN_TIMER_EN
                end else if (m_elapsed == SECS * TICKS - 1) begin
                    m_timeout = 1;
                    model_lose();
                    m_phase = P_SWITCH;
                    $display("txn timeout player=%0d left=%0d/%0d t=%0t", m_active, m_ch[0], m_ch[1], $time);
`endif
                end else begin
                    m_elapsed++;
                end
            end
            P_SCORE: begin
                if (score_ack) begin
                    if (score_win) begin
                        m_winner    = m_active;
                        m_win_valid = 1;
                        m_phase     = P_DONE;
                        $display("txn guess player=%0d 4A -> winner t=%0t", m_active, $time);
                    end else begin
                        model_lose();
                        m_phase = P_SWITCH;
                        $display("txn guess player=%0d miss left=%0d/%0d t=%0t", m_active, m_ch[0], m_ch[1], $time);
                    end
                end
            end
            P_SWITCH: begin
                if (m_ch[0] == 0 && m_ch[1] == 0) begin
                    m_draw  = 1;
                    m_phase = P_DONE;
                end else begin
                    if (m_ch[1 - m_active] > 0) m_active = 1 - m_active;
                    m_elapsed = 0;
                    m_phase   = P_ENTRY;
                end
            end
            default: model_reset();
        endcase
    endtask

    task automatic compare_all();
        check("entry_en",     32'(entry_en),      32'(m_phase == P_ENTRY));
        check("score_req",    32'(score_req),     32'(m_phase == P_SCORE));
        check("active",       32'(active_player), 32'(m_active));
        check("chances_p0",   32'(chances_p0),    32'(m_ch[0]));
        check("chances_p1",   32'(chances_p1),    32'(m_ch[1]));
        check("timeout",      32'(timeout_pulse), 32'(m_timeout));
        check("winner_valid", 32'(winner_valid),  32'(m_win_valid));
        check("winner",       32'(winner),        32'(m_winner));
        check("draw",         32'(draw),          32'(m_draw));
`ifdef TURN_TIMER_EN
        if (m_phase == P_ENTRY) begin
            check("secs_left", 32'(turn_secs_left), 32'(SECS - m_elapsed / TICKS));
        end else if (m_phase == P_IDLE) begin
            check("secs_left", 32'(turn_secs_left), 32'd0);
        end
`else
        check("secs_left", 32'(turn_secs_left), 32'd0);
`endif
    endtask

    // Apply inputs at the falling edge, step model on the rising edge, compare at the next falling edge
    task automatic cycle(input logic r, input logic s, input logic fp,
                         input logic ed, input logic ack, input logic win);
        reset        = r;
        start        = s;
        first_player = fp;
        entry_done   = ed;
        score_ack    = ack;
        score_win    = win;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; first_player = 1'b0;
        entry_done = 1'b0; score_ack = 1'b0; score_win = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: reset held two cycles while a guess is being scored
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check("t1_in_score", 32'(score_req), 32'd1);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("t1_entry_en", 32'(entry_en), 32'd0);
        check("t1_score_req", 32'(score_req), 32'd0);
        check("t1_winner_valid", 32'(winner_valid), 32'd0);
        check("t1_draw", 32'(draw), 32'd0);
        check("t1_chances", 32'({chances_p1, chances_p0}), 32'd0);

        // 2: P1 misses, turn passes to P0 with a fresh countdown
        cycle(0, 1, 1, 0, 0, 0);
        idle_cycle();
        cycle(0, 0, 0, 1, 0, 0);
        idle_cycle();
        cycle(0, 0, 0, 0, 1, 0);
        idle_cycle();
        check("t2_chances_p1", 32'(chances_p1), 32'd1);
        check("t2_chances_p0", 32'(chances_p0), 32'd2);
        check("t2_active", 32'(active_player), 32'd0);
`ifdef TURN_TIMER_EN
        check("t2_secs_left", 32'(turn_secs_left), 32'd3);

        // 3: no guess from P0 -> forfeit exactly 12 cycles into the turn
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int k = 1; k < SECS * TICKS; k++) begin
            idle_cycle();
            check("t3_no_early_timeout", 32'(timeout_pulse), 32'd0);
        end
        idle_cycle();
        check("t3_timeout_pulse", 32'(timeout_pulse), 32'd1);
        check("t3_chances_p0", 32'(chances_p0), 32'd1);
        idle_cycle();
        check("t3_pulse_width", 32'(timeout_pulse), 32'd0);
        check("t3_active", 32'(active_player), 32'd1);

        // 4: guess confirmed on the very cycle the turn would expire
        for (int k = 1; k < SECS * TICKS; k++) idle_cycle();
        cycle(0, 0, 0, 1, 0, 0);
        check("t4_no_timeout", 32'(timeout_pulse), 32'd0);
        check("t4_score_req", 32'(score_req), 32'd1);
        check("t4_chances_p1", 32'(chances_p1), 32'd2);
        cycle(0, 0, 0, 0, 1, 0);
        idle_cycle();
`endif

        // 5: four misses alternating -> draw, then a new match
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check("t5_turn_owner", 32'(active_player), 32'(k % 2));
            cycle(0, 0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 1, 0);
            idle_cycle();
        end
        check("t5_draw", 32'(draw), 32'd1);
        check("t5_winner_valid", 32'(winner_valid), 32'd0);
        check("t5_chances", 32'({chances_p1, chances_p0}), 32'd0);
        check("t5_entry_closed", 32'(entry_en), 32'd0);
        cycle(0, 1, 1, 0, 0, 0);
        check("t5_restart_draw", 32'(draw), 32'd0);
        check("t5_restart_p0", 32'(chances_p0), 32'd2);
        check("t5_restart_p1", 32'(chances_p1), 32'd2);
        check("t5_restart_active", 32'(active_player), 32'd1);

        // 6: P1 scores 4A on the first guess; later entry is ignored
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        check("t6_winner_valid", 32'(winner_valid), 32'd1);
        check("t6_winner", 32'(winner), 32'd1);
        check("t6_score_req", 32'(score_req), 32'd0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("t6_ignored_entry", 32'(entry_en), 32'd0);
        check("t6_ignored_req", 32'(score_req), 32'd0);
        check("t6_held_p1", 32'(chances_p1), 32'd2);

        // Randomized run, inputs weighted by where the model says the match is
        for (int n = 0; n < 4000; n++) begin
            logic r, s, ed, ack;
            r   = ($urandom_range(0, 299) == 0);
            s   = (m_phase == P_IDLE || m_phase == P_DONE) ? ($urandom_range(0, 3) == 0)
                                                           : ($urandom_range(0, 29) == 0);
            ed  = (m_phase == P_ENTRY) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) == 0);
            ack = (m_phase == P_SCORE) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cycle(r, s, 1'($urandom_range(0, 1)), ed, ack, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
